// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational alu between two valid/ready requesters.
// One request is granted per cycle. The granted operands go to the alu, and the
// result plus its flags land in a single result register owned by the granted
// port. The owning port drains the register through its response handshake.
//
// Configuration macro: ALU_ARB_PRIO_EN
//   undefined -> round-robin on ties (port 0 wins the first tie after reset)
//   defined   -> fixed priority, port 0 always wins ties (port 1 can starve)
//
// Handshake semantics (applies to every valid/ready pair on this block):
//   a transfer happens on a rising clock edge where valid and ready are both
//   high. A request's a/b/op must be held stable while valid is high and ready
//   is low. Ready never depends on the same port's payload, only on its valid.
module alu_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,

  // Request port 0
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [2:0]       req0_op,

  // Request port 1
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [2:0]       req1_op,

  // Response port 0
  output logic             resp0_valid,
  input  logic             resp0_ready,
  output logic [WIDTH-1:0] resp0_out,
  output logic             resp0_ovf,
  output logic             resp0_zero,
  output logic             resp0_neg,

  // Response port 1
  output logic             resp1_valid,
  input  logic             resp1_ready,
  output logic [WIDTH-1:0] resp1_out,
  output logic             resp1_ovf,
  output logic             resp1_zero,
  output logic             resp1_neg,

  // Shared alu
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_op,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_overflow,
  input  logic             alu_zero,
  input  logic             alu_negative,

  // Debug view of the result-register FSM: 0 = EMPTY, 1 = FULL
  output logic             dbg_state
);

  // Op driven onto the alu when nothing is granted (add, harmless).
  localparam logic [2:0] OP_IDLE = 3'b010;

  typedef enum logic {
    S_EMPTY = 1'b0,
    S_FULL  = 1'b1
  } state_e;

  // Registered state
  state_e           state_q;
  logic             res_port_q;
  logic [WIDTH-1:0] res_data_q;
  logic [2:0]       res_flags_q;   // {overflow, zero, negative}
  logic             last_grant_q;
  logic             resp0_valid_q;
  logic             resp1_valid_q;

  // Combinational control
  logic             any_valid;
  logic             both_valid;
  logic             grant;
  logic             owner_ready;
  logic             consume;
  logic             can_accept;
  logic             accept;

  // Next-state values for the result register, loaded on accept
  logic [WIDTH-1:0] res_data_d;
  logic [2:0]       res_flags_d;

  assign any_valid  = req0_valid | req1_valid;
  assign both_valid = req0_valid & req1_valid;

  // Pick the port to serve this cycle; ties go round-robin or to port 0.
  always_comb begin
    grant = 1'b0;
    if (both_valid) begin
`ifdef ALU_ARB_PRIO_EN
      grant = 1'b0;
`else
      grant = ~last_grant_q;
`endif
    end else if (req1_valid) begin
      grant = 1'b1;
    end else begin
      grant = 1'b0;
    end
  end

  // The register can take a new result when empty, or when its current
  // owner is draining it this very cycle (back-to-back, no bubble).
  assign owner_ready = res_port_q ? resp1_ready : resp0_ready;
  assign consume     = (state_q == S_FULL) & owner_ready;
  assign can_accept  = (state_q == S_EMPTY) | consume;

  // Reset forces both request readies low so nothing is accepted while the
  // block is being cleared.
  assign accept      = can_accept & any_valid & ~reset;
  assign req0_ready  = accept & ~grant & req0_valid;
  assign req1_ready  = accept &  grant & req1_valid;

  // Steer the granted port's operands onto the shared alu.
  always_comb begin
    alu_a  = '0;
    alu_b  = '0;
    alu_op = OP_IDLE;
    if (any_valid) begin
      if (grant) begin
        alu_a  = req1_a;
        alu_b  = req1_b;
        alu_op = req1_op;
      end else begin
        alu_a  = req0_a;
        alu_b  = req0_b;
        alu_op = req0_op;
      end
    end
  end

  // Values captured into the result register on an accept edge.
  assign res_data_d  = alu_out;
  assign res_flags_d = {alu_overflow, alu_zero, alu_negative};

  // Result-register FSM: EMPTY/FULL plus the registered response valids.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= S_EMPTY;
      res_port_q    <= 1'b0;
      res_data_q    <= '0;
      res_flags_q   <= 3'b000;
      last_grant_q  <= 1'b1;
      resp0_valid_q <= 1'b0;
      resp1_valid_q <= 1'b0;
    end else begin
      case (state_q)
        S_EMPTY: begin
          if (accept) begin
            state_q       <= S_FULL;
            res_port_q    <= grant;
            res_data_q    <= res_data_d;
            res_flags_q   <= res_flags_d;
            last_grant_q  <= grant;
            resp0_valid_q <= ~grant;
            resp1_valid_q <=  grant;
          end
        end
        S_FULL: begin
          if (accept) begin
            // Owner consumed and a new result lands in the same edge.
            state_q       <= S_FULL;
            res_port_q    <= grant;
            res_data_q    <= res_data_d;
            res_flags_q   <= res_flags_d;
            last_grant_q  <= grant;
            resp0_valid_q <= ~grant;
            resp1_valid_q <=  grant;
          end else if (consume) begin
            state_q       <= S_EMPTY;
            resp0_valid_q <= 1'b0;
            resp1_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q       <= S_EMPTY;
          resp0_valid_q <= 1'b0;
          resp1_valid_q <= 1'b0;
        end
      endcase
    end
  end

  // Result and flags go to both ports; each port's valid qualifies them.
  assign resp0_valid = resp0_valid_q;
  assign resp1_valid = resp1_valid_q;
  assign resp0_out   = res_data_q;
  assign resp1_out   = res_data_q;
  assign resp0_ovf   = res_flags_q[2];
  assign resp0_zero  = res_flags_q[1];
  assign resp0_neg   = res_flags_q[0];
  assign resp1_ovf   = res_flags_q[2];
  assign resp1_zero  = res_flags_q[1];
  assign resp1_neg   = res_flags_q[0];

  assign dbg_state   = state_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Testbench for alu_arbiter: directed vectors against a small behavioural alu,
// with hand-computed expected results. Inputs change 1 time unit after a rising
// edge; outputs are sampled on the falling edge.
module tb_alu_arbiter;

  localparam int W = 32;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;
  localparam logic [2:0] OP_NOR = 3'b110;
  localparam logic [2:0] OP_XOR = 3'b111;

  logic         clock;
  logic         reset;
  logic         req0_valid, req0_ready;
  logic [W-1:0] req0_a, req0_b;
  logic [2:0]   req0_op;
  logic         req1_valid, req1_ready;
  logic [W-1:0] req1_a, req1_b;
  logic [2:0]   req1_op;
  logic         resp0_valid, resp0_ready;
  logic [W-1:0] resp0_out;
  logic         resp0_ovf, resp0_zero, resp0_neg;
  logic         resp1_valid, resp1_ready;
  logic [W-1:0] resp1_out;
  logic         resp1_ovf, resp1_zero, resp1_neg;
  logic [W-1:0] alu_a, alu_b, alu_out;
  logic [2:0]   alu_op;
  logic         alu_overflow, alu_zero, alu_negative;
  logic         dbg_state;

  int n_checks = 0;
  int n_fail   = 0;
  logic [W-1:0] exp_q[$];

  alu_arbiter #(.WIDTH(W)) dut (
    .clock(clock), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .resp0_valid(resp0_valid), .resp0_ready(resp0_ready),
    .resp0_out(resp0_out), .resp0_ovf(resp0_ovf),
    .resp0_zero(resp0_zero), .resp0_neg(resp0_neg),
    .resp1_valid(resp1_valid), .resp1_ready(resp1_ready),
    .resp1_out(resp1_out), .resp1_ovf(resp1_ovf),
    .resp1_zero(resp1_zero), .resp1_neg(resp1_neg),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_out(alu_out), .alu_overflow(alu_overflow),
    .alu_zero(alu_zero), .alu_negative(alu_negative),
    .dbg_state(dbg_state)
  );

  // Clock
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Behavioural alu; flags are meaningful for add/sub only.
  always_comb begin
    alu_out      = '0;
    alu_overflow = 1'b0;
    case (alu_op)
      3'b010: begin
        alu_out      = alu_a + alu_b;
        alu_overflow = (alu_a[W-1] == alu_b[W-1]) && (alu_out[W-1] != alu_a[W-1]);
      end
      3'b011: begin
        alu_out      = alu_a - alu_b;
        alu_overflow = (alu_a[W-1] != alu_b[W-1]) && (alu_out[W-1] != alu_a[W-1]);
      end
      3'b100: alu_out = alu_a & alu_b;
      3'b101: alu_out = alu_a | alu_b;
      3'b110: alu_out = ~(alu_a | alu_b);
      3'b111: alu_out = alu_a ^ alu_b;
      default: alu_out = '0;
    endcase
    alu_zero     = (alu_out == '0);
    alu_negative = alu_out[W-1];
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Requester rule: payload stable while valid is high and ready is low.
  logic         pend0, pend1;
  logic [2*W+2:0] hold0, hold1;
  initial begin
    pend0 = 1'b0;
    pend1 = 1'b0;
    hold0 = '0;
    hold1 = '0;
  end
  always @(negedge clock) begin
    if (!reset) begin
      if (pend0 && req0_valid) check("req0_stable", {req0_a, req0_b, req0_op}, hold0);
      if (pend1 && req1_valid) check("req1_stable", {req1_a, req1_b, req1_op}, hold1);
    end
    pend0 = req0_valid && !req0_ready;
    pend1 = req1_valid && !req1_ready;
    hold0 = {req0_a, req0_b, req0_op};
    hold1 = {req1_a, req1_b, req1_op};
  end

  // Single request on one port, drained immediately.
  task automatic run_single(input bit port, input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic [2:0] op, input logic [W-1:0] exp_out,
                            input logic [2:0] exp_flags, input string tag);
    step();
    if (port) begin
      req1_valid = 1'b1; req1_a = a; req1_b = b; req1_op = op; resp1_ready = 1'b1;
    end else begin
      req0_valid = 1'b1; req0_a = a; req0_b = b; req0_op = op; resp0_ready = 1'b1;
    end
    @(negedge clock);
    check({tag, "_req_ready"}, port ? req1_ready : req0_ready, 1'b1);
    step();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    @(negedge clock);
    check({tag, "_resp_valid"}, port ? resp1_valid : resp0_valid, 1'b1);
    check({tag, "_resp_out"}, port ? resp1_out : resp0_out, exp_out);
    check({tag, "_flags"}, port ? {resp1_ovf, resp1_zero, resp1_neg}
                                : {resp0_ovf, resp0_zero, resp0_neg}, exp_flags);
    step();
    @(negedge clock);
    check({tag, "_drained"}, {resp0_valid, resp1_valid}, 2'b00);
  endtask

  // Safety net against a stuck run.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish within budget");
    $fatal(1, "timeout");
  end

  initial begin
    int eg;
    int prev;
    logic [W-1:0] held;

    reset = 1'b1;
    req0_valid = 1'b1; req0_a = 32'd1; req0_b = 32'd1; req0_op = OP_ADD;
    req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_op = OP_ADD;
    resp0_ready = 1'b0; resp1_ready = 1'b0;

    // Reset state
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("rst_req0_ready", req0_ready, 1'b0);
    check("rst_resp_valid", {resp0_valid, resp1_valid}, 2'b00);
    check("rst_state", dbg_state, 1'b0);
    check("rst_resp_out", resp0_out, 32'd0);
    step();
    req0_valid = 1'b0;
    reset = 1'b0;

    // Port 0 add 7+5
    run_single(1'b0, 32'd7, 32'd5, OP_ADD, 32'd12, 3'b000, "add0");

    // Reset while FULL with a held result of 5
    step();
    req0_valid = 1'b1; req0_a = 32'd2; req0_b = 32'd3; req0_op = OP_ADD; resp0_ready = 1'b0;
    @(negedge clock);
    check("mid_req_ready", req0_ready, 1'b1);
    step();
    req0_valid = 1'b0;
    @(negedge clock);
    check("mid_full_valid", resp0_valid, 1'b1);
    check("mid_full_out", resp0_out, 32'd5);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_valid", {resp0_valid, resp1_valid}, 2'b00);
    check("mid_rst_state", dbg_state, 1'b0);
    step();
    reset = 1'b0;
    resp0_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check("post_rst_no_resp", {resp0_valid, resp1_valid}, 2'b00);
    end

    // Port 1 sub 3-3, then 0x7FFFFFFF+1
    run_single(1'b1, 32'd3, 32'd3, OP_SUB, 32'd0, 3'b010, "sub1");
    run_single(1'b1, 32'h7FFF_FFFF, 32'd1, OP_ADD, 32'h8000_0000, 3'b101, "ovf1");

    // Both ports valid every cycle, both consumers ready
    step();
    req0_valid = 1'b1; req0_a = 32'd10; req0_b = 32'd1; req0_op = OP_ADD;
    req1_valid = 1'b1; req1_a = 32'd20; req1_b = 32'd2; req1_op = OP_ADD;
    resp0_ready = 1'b1; resp1_ready = 1'b1;
    prev = -1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
`ifdef ALU_ARB_PRIO_EN
      eg = 0;
`else
      eg = i % 2;
`endif
      check("rr_ready0", req0_ready, (eg == 0));
      check("rr_ready1", req1_ready, (eg == 1));
      if (prev >= 0) begin
        check("rr_resp_valid", {resp1_valid, resp0_valid}, (prev == 1) ? 2'b10 : 2'b01);
        check("rr_resp_out", (prev == 1) ? resp1_out : resp0_out, (prev == 1) ? 32'd22 : 32'd11);
      end
      prev = eg;
      if (i < 5) step();
    end
    step();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    @(negedge clock);
    check("rr_last_valid", {resp1_valid, resp0_valid}, (prev == 1) ? 2'b10 : 2'b01);
    check("rr_last_out", (prev == 1) ? resp1_out : resp0_out, (prev == 1) ? 32'd22 : 32'd11);
    step();
    @(negedge clock);
    check("rr_drained", {resp0_valid, resp1_valid}, 2'b00);

    // Backpressure from port 0 blocks a pending port 1 request
    step();
    req0_valid = 1'b1; req0_a = 32'd100; req0_b = 32'd1; req0_op = OP_ADD;
    resp0_ready = 1'b0; resp1_ready = 1'b0;
    @(negedge clock);
    check("bp_req0_ready", req0_ready, 1'b1);
    step();
    req0_valid = 1'b0;
    req1_valid = 1'b1; req1_a = 32'd4; req1_b = 32'd4; req1_op = OP_ADD;
    held = 32'd101;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      check("bp_req1_blocked", req1_ready, 1'b0);
      check("bp_resp0_valid", resp0_valid, 1'b1);
      check("bp_resp0_stable", resp0_out, held);
      step();
    end
    resp0_ready = 1'b1;
    @(negedge clock);
    check("bp_release_ready1", req1_ready, 1'b1);
    step();
    req1_valid = 1'b0;
    resp0_ready = 1'b0;
    resp1_ready = 1'b1;
    @(negedge clock);
    check("bp_resp1_valid", {resp1_valid, resp0_valid}, 2'b10);
    check("bp_resp1_out", resp1_out, 32'd8);
    step();
    @(negedge clock);
    check("bp_drained", {resp0_valid, resp1_valid}, 2'b00);

    // Back-to-back on port 0: xor then nor
    exp_q.push_back(32'h0000_0FF0);
    exp_q.push_back(32'hFFFF_FFFF);
    step();
    resp0_ready = 1'b1; resp1_ready = 1'b0;
    req0_valid = 1'b1; req0_a = 32'h0000_F0F0; req0_b = 32'h0000_FF00; req0_op = OP_XOR;
    @(negedge clock);
    check("b2b_ready_xor", req0_ready, 1'b1);
    step();
    req0_a = 32'd0; req0_b = 32'd0; req0_op = OP_NOR;
    @(negedge clock);
    check("b2b_ready_nor", req0_ready, 1'b1);
    check("b2b_valid_xor", resp0_valid, 1'b1);
    check("b2b_out_xor", resp0_out, exp_q.pop_front());
    step();
    req0_valid = 1'b0;
    @(negedge clock);
    check("b2b_valid_nor", resp0_valid, 1'b1);
    check("b2b_state_full", dbg_state, 1'b1);
    check("b2b_out_nor", resp0_out, exp_q.pop_front());
    step();
    @(negedge clock);
    check("b2b_state_empty", dbg_state, 1'b0);
    check("b2b_queue_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
